// File: rtl/onchip_ram_dualport.sv
// onchip_ram_dualport: on-chip RAM with two independent Avalon-MM slave ports
// (s1, s2) sharing one storage array.
//   clk, reset            : clock, async active-high reset (read pipeline only)
//   clken, reset_req      : ce = clken & ~reset_req; ce=0 stalls both ports
//   freeze                : blocks all writes on both ports
//   sX_address/chipselect/read/write/byteenable/writedata : request side
//   sX_readdata/readdatavalid : response, READ_LATENCY enabled cycles after accept
// Collision rules: same-port RDW returns old or merged data (RDW_NEW),
// cross-port reads see old data, and s1 wins per byte lane on a double write.

// Per-port read pipeline. vld_pipe[0]/dat_pipe[0] are the accept-cycle
// request; stages 1..LAT are registers that only advance while ce=1.
module onchip_ram_dualport_rdpipe #(
  parameter int DW  = 32,
  parameter int LAT = 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          ce,
  input  logic          acc,
  input  logic [DW-1:0] din,
  output logic [DW-1:0] dout,
  output logic          valid
);
  logic [LAT:1]          vld_q;
  logic [LAT:1][DW-1:0]  dat_q;
  logic [LAT:0]          vld_pipe;
  logic [LAT:0][DW-1:0]  dat_pipe;

  assign vld_pipe = {vld_q, acc};
  assign dat_pipe = {dat_q, din};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      vld_q <= '0;
      dat_q <= '0;
    end else if (ce) begin
      vld_q <= vld_pipe[LAT-1:0];
      // data only moves with a valid so readdata holds between pulses
      for (int s = 1; s <= LAT; s++)
        if (vld_pipe[s-1]) dat_q[s] <= dat_pipe[s-1];
    end
  end

  // a valid held through a stall is masked, then reappears once ce returns
  assign valid = vld_pipe[LAT] & ce;
  assign dout  = dat_pipe[LAT];
endmodule

module onchip_ram_dualport #(
  parameter     INIT_FILE    = "onchip_ram_dualport.hex",
  parameter int DATA_WIDTH   = 32,
  parameter int DEPTH        = 2560,
  parameter int ADDR_WIDTH   = 12,
  parameter int READ_LATENCY = 1,
  parameter int RDW_NEW      = 0
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    clken,
  input  logic                    reset_req,
  input  logic                    freeze,
  input  logic [ADDR_WIDTH-1:0]   s1_address,
  input  logic                    s1_chipselect,
  input  logic                    s1_read,
  input  logic                    s1_write,
  input  logic [DATA_WIDTH/8-1:0] s1_byteenable,
  input  logic [DATA_WIDTH-1:0]   s1_writedata,
  output logic [DATA_WIDTH-1:0]   s1_readdata,
  output logic                    s1_readdatavalid,
  input  logic [ADDR_WIDTH-1:0]   s2_address,
  input  logic                    s2_chipselect,
  input  logic                    s2_read,
  input  logic                    s2_write,
  input  logic [DATA_WIDTH/8-1:0] s2_byteenable,
  input  logic [DATA_WIDTH-1:0]   s2_writedata,
  output logic [DATA_WIDTH-1:0]   s2_readdata,
  output logic                    s2_readdatavalid
);
  localparam int NB = DATA_WIDTH / 8;
  localparam int NP = 2;
  localparam logic [ADDR_WIDTH:0] DEPTH_W = (ADDR_WIDTH+1)'(DEPTH);

  if ((READ_LATENCY != 1 && READ_LATENCY != 2) || (DATA_WIDTH % 8 != 0) ||
      ($bits(INIT_FILE) == 0)) begin : g_bad_param
    $error("onchip_ram_dualport: illegal parameter set");
  end

  logic ce;
  assign ce = clken & ~reset_req;

  // index 0 = s1, index 1 = s2
  logic [NP-1:0][ADDR_WIDTH-1:0] addr;
  logic [NP-1:0]                 cs, rd, wr;
  logic [NP-1:0][NB-1:0]         be;
  logic [NP-1:0][DATA_WIDTH-1:0] wd;
  assign addr = {s2_address, s1_address};
  assign cs   = {s2_chipselect, s1_chipselect};
  assign rd   = {s2_read, s1_read};
  assign wr   = {s2_write, s1_write};
  assign be   = {s2_byteenable, s1_byteenable};
  assign wd   = {s2_writedata, s1_writedata};

  logic [NP-1:0]                 in_range, rd_acc, wr_en, rd_valid;
  logic [NP-1:0][DATA_WIDTH-1:0] rd_word, rd_din, rd_data;

  (* ram_init_file = INIT_FILE *)
  logic [DATA_WIDTH-1:0] mem [0:DEPTH-1];

  always_comb begin
    for (int p = 0; p < NP; p++) begin
      in_range[p] = {1'b0, addr[p]} < DEPTH_W;
      rd_acc[p]   = cs[p] & rd[p] & ce;
      // out-of-range writes are dropped here so they never merge into a read
      wr_en[p]    = cs[p] & wr[p] & ce & ~freeze & in_range[p];
      rd_word[p]  = in_range[p] ? mem[addr[p]] : '0;
      rd_din[p]   = rd_word[p];
      // only the port's own write can merge; cross-port reads stay old
      if (RDW_NEW != 0 && wr_en[p])
        for (int b = 0; b < NB; b++)
          if (be[p][b]) rd_din[p][b*8 +: 8] = wd[p][b*8 +: 8];
    end
  end

  // s2 is applied first so s1's assignment wins on lanes both ports enable
  always_ff @(posedge clk) begin
    for (int p = NP-1; p >= 0; p--)
      if (wr_en[p])
        for (int b = 0; b < NB; b++)
          if (be[p][b]) mem[addr[p]][b*8 +: 8] <= wd[p][b*8 +: 8];
  end

  for (genvar p = 0; p < NP; p++) begin : g_port
    onchip_ram_dualport_rdpipe #(.DW(DATA_WIDTH), .LAT(READ_LATENCY)) u_rdpipe (
      .clk   (clk),
      .reset (reset),
      .ce    (ce),
      .acc   (rd_acc[p]),
      .din   (rd_din[p]),
      .dout  (rd_data[p]),
      .valid (rd_valid[p])
    );
  end

  assign s1_readdata      = rd_data[0];
  assign s1_readdatavalid = rd_valid[0];
  assign s2_readdata      = rd_data[1];
  assign s2_readdatavalid = rd_valid[1];
endmodule

// File: tb/tb_onchip_ram_dualport.sv
// Directed bench for onchip_ram_dualport. Two instances share every input:
// u_l1 (READ_LATENCY=1, old-data RDW) and u_l2 (READ_LATENCY=2, new-data RDW).
// DEPTH=20 with 5 address bits leaves room for out-of-range addresses.
module tb_onchip_ram_dualport;
  logic        clk = 1'b0;
  logic        reset, clken, reset_req, freeze;
  logic [4:0]  s1_address, s2_address;
  logic        s1_chipselect, s1_read, s1_write, s2_chipselect, s2_read, s2_write;
  logic [3:0]  s1_byteenable, s2_byteenable;
  logic [31:0] s1_writedata, s2_writedata;
  logic [31:0] a_s1_rd, a_s2_rd, b_s1_rd, b_s2_rd;
  logic        a_s1_v, a_s2_v, b_s1_v, b_s2_v;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  onchip_ram_dualport #(.DATA_WIDTH(32), .DEPTH(20), .ADDR_WIDTH(5),
                        .READ_LATENCY(1), .RDW_NEW(0)) u_l1 (
    .clk(clk), .reset(reset), .clken(clken), .reset_req(reset_req), .freeze(freeze),
    .s1_address(s1_address), .s1_chipselect(s1_chipselect), .s1_read(s1_read),
    .s1_write(s1_write), .s1_byteenable(s1_byteenable), .s1_writedata(s1_writedata),
    .s1_readdata(a_s1_rd), .s1_readdatavalid(a_s1_v),
    .s2_address(s2_address), .s2_chipselect(s2_chipselect), .s2_read(s2_read),
    .s2_write(s2_write), .s2_byteenable(s2_byteenable), .s2_writedata(s2_writedata),
    .s2_readdata(a_s2_rd), .s2_readdatavalid(a_s2_v));

  onchip_ram_dualport #(.DATA_WIDTH(32), .DEPTH(20), .ADDR_WIDTH(5),
                        .READ_LATENCY(2), .RDW_NEW(1)) u_l2 (
    .clk(clk), .reset(reset), .clken(clken), .reset_req(reset_req), .freeze(freeze),
    .s1_address(s1_address), .s1_chipselect(s1_chipselect), .s1_read(s1_read),
    .s1_write(s1_write), .s1_byteenable(s1_byteenable), .s1_writedata(s1_writedata),
    .s1_readdata(b_s1_rd), .s1_readdatavalid(b_s1_v),
    .s2_address(s2_address), .s2_chipselect(s2_chipselect), .s2_read(s2_read),
    .s2_write(s2_write), .s2_byteenable(s2_byteenable), .s2_writedata(s2_writedata),
    .s2_readdata(b_s2_rd), .s2_readdatavalid(b_s2_v));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear();
    s1_chipselect = 0; s1_read = 0; s1_write = 0; s1_byteenable = 0;
    s1_address = 0; s1_writedata = 0;
    s2_chipselect = 0; s2_read = 0; s2_write = 0; s2_byteenable = 0;
    s2_address = 0; s2_writedata = 0;
  endtask

  task automatic p1(input logic r, input logic w, input logic [4:0] a,
                    input logic [31:0] d, input logic [3:0] e);
    s1_chipselect = 1; s1_read = r; s1_write = w; s1_address = a;
    s1_writedata = d; s1_byteenable = e;
  endtask

  task automatic p2(input logic r, input logic w, input logic [4:0] a,
                    input logic [31:0] d, input logic [3:0] e);
    s2_chipselect = 1; s2_read = r; s2_write = w; s2_address = a;
    s2_writedata = d; s2_byteenable = e;
  endtask

  initial begin
    bit          ck [10] = '{1, 1, 0, 0, 1, 1, 1, 1, 1, 1};
    logic [4:0]  ra [4]  = '{5'd3, 5'd5, 5'd7, 5'd9};
    logic [31:0] ex [4]  = '{32'h11BB33DD, 32'hA5A55678, 32'h00220011, 32'hCAFEF00D};
    int k = 0, na = 0, nb = 0;

    reset = 1; clken = 1; reset_req = 0; freeze = 0;
    clear();
    tick();
    chk("rst_l1_s1_data", a_s1_rd, 0);
    chk("rst_l1_s1_vld", 32'(a_s1_v), 0);
    chk("rst_l2_s2_data", b_s2_rd, 0);
    chk("rst_l2_s2_vld", 32'(b_s2_v), 0);
    reset = 0;
    tick();

    // preload
    p1(0, 1, 5, 32'h12345678, 4'hF); p2(0, 1, 3, 32'h11223344, 4'hF); tick(); clear();
    p1(0, 1, 7, 32'h0, 4'hF); p2(0, 1, 9, 32'hCAFEF00D, 4'hF); tick(); clear();

    // read latency 1 vs 2
    p1(1, 0, 5, 0, 0); tick(); clear();
    chk("lat1_vld", 32'(a_s1_v), 1);
    chk("lat1_data", a_s1_rd, 32'h12345678);
    chk("lat2_early_vld", 32'(b_s1_v), 0);
    tick();
    chk("lat1_vld_drop", 32'(a_s1_v), 0);
    chk("lat1_data_hold", a_s1_rd, 32'h12345678);
    chk("lat2_vld", 32'(b_s1_v), 1);
    chk("lat2_data", b_s1_rd, 32'h12345678);

    // byte-enable write on s1, read back on s2
    p1(0, 1, 3, 32'hAABBCCDD, 4'b0101); tick(); clear();
    p2(1, 0, 3, 0, 0); tick(); clear();
    chk("be_l1_vld", 32'(a_s2_v), 1);
    chk("be_l1_data", a_s2_rd, 32'h11BB33DD);
    tick();
    chk("be_l2_data", b_s2_rd, 32'h11BB33DD);

    // cross-port write collision: s1 wins shared lanes
    p1(0, 1, 7, 32'h000000FF, 4'b0011); p2(0, 1, 7, 32'h0000EE00, 4'b0010); tick(); clear();
    p1(1, 0, 7, 0, 0); tick(); clear();
    chk("coll1_l1", a_s1_rd, 32'h000000FF);
    tick();
    chk("coll1_l2", b_s1_rd, 32'h000000FF);
    p1(0, 1, 7, 32'h11111111, 4'b0001); p2(0, 1, 7, 32'h22222222, 4'b0101); tick(); clear();
    p1(1, 0, 7, 0, 0); tick(); clear();
    chk("coll2_l1", a_s1_rd, 32'h00220011);
    tick();
    chk("coll2_l2", b_s1_rd, 32'h00220011);

    // freeze blocks the s2 write, s1 read in the same cycle still completes
    freeze = 1; p2(0, 1, 9, 32'hDEADBEEF, 4'hF); p1(1, 0, 9, 0, 0); tick(); freeze = 0; clear();
    chk("frz_rd_vld", 32'(a_s1_v), 1);
    chk("frz_rd_data", a_s1_rd, 32'hCAFEF00D);
    tick();
    chk("frz_rd_l2", b_s1_rd, 32'hCAFEF00D);
    p1(1, 0, 9, 0, 0); tick(); clear();
    chk("frz_after_l1", a_s1_rd, 32'hCAFEF00D);
    tick();
    chk("frz_after_l2", b_s1_rd, 32'hCAFEF00D);

    // same-port RDW (old on u_l1, merged on u_l2), cross-port read sees old
    p1(1, 1, 5, 32'hA5A5A5A5, 4'b1100); p2(1, 0, 5, 0, 0); tick(); clear();
    chk("rdw_old_l1", a_s1_rd, 32'h12345678);
    chk("xrd_old_l1", a_s2_rd, 32'h12345678);
    tick();
    chk("rdw_new_l2", b_s1_rd, 32'hA5A55678);
    chk("xrd_old_l2", b_s2_rd, 32'h12345678);

    // out-of-range: write ignored, read returns 0
    p1(0, 1, 25, 32'hFFFFFFFF, 4'hF); p2(1, 0, 25, 0, 0); tick(); clear();
    chk("oob_l1_vld", 32'(a_s2_v), 1);
    chk("oob_l1_data", a_s2_rd, 0);
    tick();
    chk("oob_l2_vld", 32'(b_s2_v), 1);
    chk("oob_l2_data", b_s2_rd, 0);

    // reset_req blocks acceptance
    reset_req = 1; p2(1, 0, 3, 0, 0); tick(); reset_req = 0; clear();
    chk("rreq_l1_vld", 32'(a_s2_v), 0);
    tick();
    chk("rreq_l2_vld", 32'(b_s2_v), 0);

    // four streamed reads with a two-cycle clken stall
    for (int i = 0; i < 10; i++) begin
      clear();
      clken = ck[i];
      if (ck[i] && k < 4) begin p1(1, 0, ra[k], 0, 0); k++; end
      #1;
      if (!clken) begin
        chk("stall_vld_l1", 32'(a_s1_v), 0);
        chk("stall_vld_l2", 32'(b_s1_v), 0);
      end
      if (a_s1_v) begin
        if (na < 4) chk("stream_l1", a_s1_rd, ex[na]);
        na++;
      end
      if (b_s1_v) begin
        if (nb < 4) chk("stream_l2", b_s1_rd, ex[nb]);
        nb++;
      end
      tick();
    end
    clear(); clken = 1;
    chk("stream_cnt_l1", 32'(na), 4);
    chk("stream_cnt_l2", 32'(nb), 4);

    // reset while a latency-2 read is in flight
    p1(1, 0, 3, 0, 0); tick(); clear();
    reset = 1; #1;
    chk("rst_fl_vld", 32'(b_s1_v), 0);
    chk("rst_fl_data_l2", b_s1_rd, 0);
    chk("rst_fl_data_l1", a_s1_rd, 0);
    tick();
    reset = 0;
    tick();
    chk("rst_fl_vld2", 32'(b_s1_v), 0);
    tick();
    chk("rst_fl_vld3", 32'(b_s1_v), 0);

    // memory survives reset
    p1(1, 0, 3, 0, 0); tick(); clear();
    chk("mem_keep_l1", a_s1_rd, 32'h11BB33DD);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
